// File: rtl/cntr_drv_pkg.sv
// cntr_drv_pkg: shared state encoding and default width for the counter command driver.
package cntr_drv_pkg;
    localparam int CNTR_DRV_WIDTH_DEF = 8;
    typedef enum logic [1:0] {IDLE, LOAD, INC, CHECK} cntr_drv_state_t;
endpackage

// File: rtl/counter_shadow.sv
// counter_shadow: expected-count register and sticky 4-state compare against the counter's q.
module counter_shadow
    import cntr_drv_pkg::*;
#(
    parameter int WIDTH = CNTR_DRV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic             inc_i,
    input  logic             done_i,
    input  logic [WIDTH-1:0] val_i,
    input  logic [WIDTH-1:0] q_i,
    output logic             err_o
);
    logic [WIDTH-1:0] exp_q;
    logic             post_q;
    logic             err_q;
    logic             err_d;
    logic             chk;

    // The cycle right after LOAD is excluded from comparison.
    assign chk   = (inc_i | done_i) & ~post_q & (q_i !== exp_q);
    assign err_d = clr_i ? 1'b0 : (err_q | chk);
    assign err_o = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q  <= '0;
            post_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            post_q <= ld_i;
            exp_q  <= ld_i ? val_i : (inc_i ? exp_q + 1'b1 : exp_q);
            err_q  <= err_d;
        end
    end
endmodule

// File: rtl/counter_cmd_driver.sv
// counter_cmd_driver: turns one "load V, increment K times" command into ld/inc cycles and reports the final q.
// Define CNTR_DRV_CHECK_EN to add the counter_shadow checker driving err; otherwise err is tied to 0.
module counter_cmd_driver
    import cntr_drv_pkg::*;
#(
    parameter int WIDTH = CNTR_DRV_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_load_val,
    input  logic [WIDTH-1:0] cmd_inc_cnt,
    output logic [WIDTH-1:0] data_in,
    output logic             ld,
    output logic             inc,
    input  logic [WIDTH-1:0] q,
    output logic             done,
    output logic [WIDTH-1:0] final_q,
    output logic             err
);
    cntr_drv_state_t  state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] data_in_q;
    logic [WIDTH-1:0] final_q_q;
    logic             ld_q;
    logic             inc_q;
    logic             done_q;
    logic             rdy_q;
    logic             acc;

    assign acc       = cmd_valid & rdy_q & (state_q == IDLE);
    assign cmd_ready = rdy_q;
    assign data_in   = data_in_q;
    assign ld        = ld_q;
    assign inc       = inc_q;
    assign done      = done_q;
    assign final_q   = final_q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            data_in_q <= '0;
            final_q_q <= '0;
            ld_q      <= 1'b0;
            inc_q     <= 1'b0;
            done_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    rdy_q <= ~acc;
                    if (acc) begin
                        state_q   <= LOAD;
                        ld_q      <= 1'b1;
                        data_in_q <= cmd_load_val;
                        rem_q     <= cmd_inc_cnt;
                    end
                end
                LOAD: begin
                    ld_q <= 1'b0;
                    if (rem_q != '0) begin
                        state_q <= INC;
                        inc_q   <= 1'b1;
                    end else begin
                        state_q <= CHECK;
                        done_q  <= 1'b1;
                    end
                end
                INC: begin
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == WIDTH'(1)) begin
                        state_q <= CHECK;
                        inc_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                CHECK: begin
                    final_q_q <= q;
                    rdy_q     <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

`ifdef CNTR_DRV_CHECK_EN
    counter_shadow #(.WIDTH(WIDTH)) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (acc),
        .ld_i   (ld_q),
        .inc_i  (inc_q),
        .done_i (done_q),
        .val_i  (data_in_q),
        .q_i    (q),
        .err_o  (err)
    );
`else
    assign err = 1'b0;
`endif
endmodule
